// File: rtl/adder_pkg.sv
// Shared definitions for the Brent-Kung prefix adders and subtractors.
//   bk_dir_e     : selects an up-sweep or down-sweep prefix level
//   clog2w()     : ceil(log2(w)) usable in constant expressions
//   gp_combine() : (g,p) prefix operator, {g, p} = {gh | ph&gl, ph&pl}
//   BKS_*        : pipeline depth and level counts for the default 16-bit width
package adder_pkg;

    typedef enum logic {
        BkUp,
        BkDown
    } bk_dir_e;

    function automatic int unsigned clog2w(input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < w; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned BKS_STAGES    = 3;
    localparam int unsigned BKS_DEF_WIDTH = 16;
    localparam int unsigned BKS_UP_LVLS   = clog2w(BKS_DEF_WIDTH);
    localparam int unsigned BKS_DN_LVLS   = clog2w(BKS_DEF_WIDTH) - 1;

    // Returns {g, p} of the span formed by a high group (gh, ph) over a low group (gl, pl).
    function automatic logic [1:0] gp_combine(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

endpackage

// File: rtl/bka_prefix_level.sv
// One combinational Brent-Kung prefix level.
//   Parameters: WIDTH (bits), LEVEL (span = 2**LEVEL), DIR (BkUp / BkDown)
//   Ports:
//     g, p   : group generate/propagate entering this level
//     gn, pn : group generate/propagate leaving this level
// Up level:   node i where (i+1) % 2**(LEVEL+1) == 0 absorbs node i - 2**LEVEL.
// Down level: node i where (i+1) % 2**(LEVEL+1) == 2**LEVEL, i > 2**LEVEL,
//             absorbs node i - 2**LEVEL (the already complete prefix below it).
// All other nodes pass through unchanged.
module bka_prefix_level
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEVEL = 0,
    parameter bk_dir_e     DIR   = BkUp
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] gn,
    output logic [WIDTH-1:0] pn
);

    localparam int Span = 1 << LEVEL;
    localparam int Blk  = Span << 1;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if ((DIR == BkUp && ((i + 1) % Blk) == 0) ||
            (DIR == BkDown && ((i + 1) % Blk) == Span && i > Span)) begin : g_node
            assign {gn[i], pn[i]} = gp_combine(g[i], p[i], g[i-Span], p[i-Span]);
        end else begin : g_pass
            assign gn[i] = g[i];
            assign pn[i] = p[i];
        end
    end

endmodule

// File: rtl/subtractor_bks_pipe.sv
// Pipelined Brent-Kung subtractor: {bo, d} = a - b - bi, computed as a + ~b + ~bi.
// Three registered stages (operand, up-sweep, down-sweep + difference), one result per
// clock, valid/ready on both sides. All stages advance together when the output stage
// is empty or being drained.
//   Parameters: WIDTH (power of two, 4..64)
//   Ports:
//     clk, rst             : clock, asynchronous active-high reset
//     in_valid, in_ready   : input handshake for a, b, bi
//     a, b, bi             : minuend, subtrahend, borrow-in
//     out_valid, out_ready : output handshake
//     dout                 : {bo, d}; named dout since `do` is a reserved word
//     ovf                  : signed overflow, present only with SUBTRACTOR_BKS_OVF_EN
// Build option: `define SUBTRACTOR_BKS_OVF_EN adds the ovf port and its pipeline flops.
module subtractor_bks_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SUBTRACTOR_BKS_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   dout
);

    localparam int unsigned UpLvls = clog2w(WIDTH);
    localparam int unsigned DnLvls = UpLvls - 1;

    logic en;
    logic v1_q, v2_q, v3_q;

    // Stage 1: bitwise propagate, generate (carry-in folded into bit 0), carry-in
    logic [WIDTH-1:0] p_in, g_in;
    logic             c0_in;
    logic [WIDTH-1:0] p1_q, g1_q;
    logic             c01_q;

    // Stage 2: up-sweep result plus the bitwise propagate needed for the difference
    logic [WIDTH-1:0] gu2_q, pu2_q, p2_q;
    logic             c02_q;

    // Stage 3: difference and borrow-out
    logic [WIDTH-1:0] g_fin, carry, d_next;
    logic [WIDTH:0]   dout_q;

    assign en        = ~v3_q | out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign dout      = dout_q;

    always_comb begin
        c0_in    = ~bi;
        p_in     = a ^ ~b;
        g_in     = a & ~b;
        g_in[0]  = g_in[0] | (p_in[0] & c0_in);
    end

    // Up-sweep levels, fed from stage 1
    for (genvar l = 0; l < int'(UpLvls); l++) begin : g_up
        logic [WIDTH-1:0] go, po;
        if (l == 0) begin : g_first
            bka_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (l),
                .DIR   (BkUp)
            ) u_lvl (
                .g  (g1_q),
                .p  (p1_q),
                .gn (go),
                .pn (po)
            );
        end else begin : g_next
            bka_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (l),
                .DIR   (BkUp)
            ) u_lvl (
                .g  (g_up[l-1].go),
                .p  (g_up[l-1].po),
                .gn (go),
                .pn (po)
            );
        end
    end

    // Down-sweep levels, fed from stage 2; spans shrink from 2**(UpLvls-2) to 1
    for (genvar j = 0; j < int'(DnLvls); j++) begin : g_dn
        logic [WIDTH-1:0] go, po;
        if (j == 0) begin : g_first
            bka_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (DnLvls - 1 - j),
                .DIR   (BkDown)
            ) u_lvl (
                .g  (gu2_q),
                .p  (pu2_q),
                .gn (go),
                .pn (po)
            );
        end else begin : g_next
            bka_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (DnLvls - 1 - j),
                .DIR   (BkDown)
            ) u_lvl (
                .g  (g_dn[j-1].go),
                .p  (g_dn[j-1].po),
                .gn (go),
                .pn (po)
            );
        end
    end

    // Only the final group generates matter once the prefix is complete.
    logic unused_p_fin;
    assign unused_p_fin = ^g_dn[DnLvls-1].po;

    // g_fin[i] is the carry out of bit i; carry into bit 0 is c0 itself.
    assign g_fin  = g_dn[DnLvls-1].go;
    assign carry  = {g_fin[WIDTH-2:0], c02_q};
    assign d_next = p2_q ^ carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p1_q   <= '0;
            g1_q   <= '0;
            c01_q  <= 1'b0;
            gu2_q  <= '0;
            pu2_q  <= '0;
            p2_q   <= '0;
            c02_q  <= 1'b0;
            dout_q <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            p1_q   <= p_in;
            g1_q   <= g_in;
            c01_q  <= c0_in;
            gu2_q  <= g_up[UpLvls-1].go;
            pu2_q  <= g_up[UpLvls-1].po;
            p2_q   <= p1_q;
            c02_q  <= c01_q;
            dout_q <= {~g_fin[WIDTH-1], d_next};
        end
    end

`ifdef SUBTRACTOR_BKS_OVF_EN
    // Operand signs travel with the data; the result sign is only known in stage 3.
    logic sd1_q, am1_q, sd2_q, am2_q, ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd1_q <= 1'b0;
            am1_q <= 1'b0;
            sd2_q <= 1'b0;
            am2_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (en) begin
            sd1_q <= a[WIDTH-1] ^ b[WIDTH-1];
            am1_q <= a[WIDTH-1];
            sd2_q <= sd1_q;
            am2_q <= am1_q;
            ovf_q <= sd2_q & (am2_q ^ d_next[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
